// File: rtl/alu_arbiter_pkg.sv
// Shared opcode values, FSM state encoding and helpers for alu_arbiter and alu.
package alu_arbiter_pkg;

    localparam int OC_WIDTH       = 4;
    localparam int OC_ILLEGAL_BIT = 3;

    localparam logic [OC_WIDTH-1:0] OC_ADD = 4'd0;
    localparam logic [OC_WIDTH-1:0] OC_SUB = 4'd1;
    localparam logic [OC_WIDTH-1:0] OC_MUL = 4'd2;
    localparam logic [OC_WIDTH-1:0] OC_DIV = 4'd3;
    localparam logic [OC_WIDTH-1:0] OC_NOT = 4'd4;
    localparam logic [OC_WIDTH-1:0] OC_XOR = 4'd5;
    localparam logic [OC_WIDTH-1:0] OC_OR  = 4'd6;
    localparam logic [OC_WIDTH-1:0] OC_AND = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Opcodes with the top bit set have no ALU operation behind them.
    function automatic logic oc_is_illegal(input logic [OC_WIDTH-1:0] oc);
        return oc[OC_ILLEGAL_BIT];
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: eight operations selected by a 4-bit opcode, results truncated to DATA_WIDTH.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [OC_WIDTH-1:0]   oc_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] f_o
);

    // Opcode decode; divide by zero and illegal opcodes produce 0 rather than X.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned and infers a latch.
        f_o = '0;
        case (oc_i)
            OC_ADD:  f_o = a_i + b_i;
            OC_SUB:  f_o = a_i - b_i;
            OC_MUL:  f_o = a_i * b_i;
            OC_DIV:  f_o = (b_i == '0) ? '0 : a_i / b_i;
            OC_NOT:  f_o = ~a_i;
            OC_XOR:  f_o = a_i ^ b_i;
            OC_OR:   f_o = a_i | b_i;
            OC_AND:  f_o = a_i & b_i;
            default: f_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu between two requesters; one operation in flight at a time.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [OC_WIDTH-1:0]   req0_oc,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [OC_WIDTH-1:0]   req1_oc,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_f,
    output logic                  rsp_err,
    output logic                  busy
);

    state_t                state_q, state_d;
    logic                  last_id_q, last_id_d;
    logic [OC_WIDTH-1:0]   oc_q, oc_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  id_q, id_d;
    logic [DATA_WIDTH-1:0] rsp_f_q, rsp_f_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_id_q, rsp_id_d;

    logic                  any_valid;
    logic                  grant_id;
    logic                  accept;
    logic                  exec_err;
    logic [DATA_WIDTH-1:0] alu_f;

    // With both requesters valid the one that did not win last time gets the grant.
    assign any_valid = req0_valid | req1_valid;
    assign grant_id  = (req0_valid && req1_valid) ? ~last_id_q : req1_valid;
    assign accept    = (state_q == ST_IDLE) && any_valid;

    // Readies are masked by rst_n so nothing looks accepted while reset is held.
    assign req0_ready = accept && rst_n && !grant_id;
    assign req1_ready = accept && rst_n && grant_id;

    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_f     = rsp_f_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_id    = rsp_id_q;

    // Divide by zero overrides the alu output just like an illegal opcode.
    assign exec_err = oc_is_illegal(oc_q) || ((oc_q == OC_DIV) && (b_q == '0));

    alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .oc_i(oc_q),
        .a_i (a_q),
        .b_i (b_q),
        .f_o (alu_f)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: IDLE -> EXEC on grant, EXEC -> RESP, RESP holds until the consumer takes the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture and round-robin pointer, loaded only in the accept cycle.
    always_comb begin
        oc_d      = oc_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        if (accept) begin
            oc_d      = grant_id ? req1_oc : req0_oc;
            a_d       = grant_id ? req1_a  : req0_a;
            b_d       = grant_id ? req1_b  : req0_b;
            id_d      = grant_id;
            last_id_d = grant_id;
        end
    end

    // Result registers, loaded from the alu in EXEC and held through RESP.
    always_comb begin
        rsp_f_d   = rsp_f_q;
        rsp_err_d = rsp_err_q;
        rsp_id_d  = rsp_id_q;
        if (state_q == ST_EXEC) begin
            rsp_err_d = exec_err;
            rsp_f_d   = exec_err ? '0 : alu_f;
            rsp_id_d  = id_q;
        end
    end

    // Datapath registers; last_id resets to 1 so requester 0 wins the first contested grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand registers are reset too, so the alu never sees X inputs after reset.
            oc_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
            rsp_f_q   <= '0;
            rsp_err_q <= 1'b0;
            rsp_id_q  <= 1'b0;
        end else begin
            oc_q      <= oc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
            rsp_f_q   <= rsp_f_d;
            rsp_err_q <= rsp_err_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed steps plus randomized traffic against a behavioural model.
module tb_alu_arbiter;

    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req0_ready;
    logic [3:0]    req0_oc;
    logic [DW-1:0] req0_a, req0_b;
    logic          req1_valid, req1_ready;
    logic [3:0]    req1_oc;
    logic [DW-1:0] req1_a, req1_b;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [DW-1:0] rsp_f;

    int n_cmp = 0;
    int n_bad = 0;
    int mdl_last;   // requester that won the most recent grant in the model

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_oc   (req0_oc),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_oc   (req1_oc),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_f     (rsp_f),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result {err, f} computed with plain integer arithmetic modulo 2^16.
    function automatic logic [16:0] ref_result(input logic [3:0] oc, input logic [15:0] a, input logic [15:0] b);
        longint ua;
        longint ub;
        longint r;
        logic   err;
        ua  = longint'(a);
        ub  = longint'(b);
        r   = 0;
        err = 1'b0;
        case (oc)
            4'd0: r = ua + ub;
            4'd1: r = ua - ub + 65536;
            4'd2: r = ua * ub;
            4'd3: if (ub == 0) err = 1'b1; else r = ua / ub;
            4'd4: r = 65535 - ua;
            4'd5: r = ua ^ ub;
            4'd6: r = ua | ub;
            4'd7: r = ua & ub;
            default: err = 1'b1;
        endcase
        return {err, 16'(r % 65536)};
    endfunction

    // Model arbitration: a lone requester wins; two requesters alternate with the previous winner.
    function automatic int ref_grant(input logic v0, input logic v1);
        if (v0 && v1) return (mdl_last == 0) ? 1 : 0;
        return v1 ? 1 : 0;
    endfunction

    // One full operation with rsp_ready high; starts and ends at a falling edge with the DUT in IDLE.
    task automatic transact(input logic v0, input logic [3:0] oc0, input logic [15:0] a0, input logic [15:0] b0,
                            input logic v1, input logic [3:0] oc1, input logic [15:0] a1, input logic [15:0] b1);
        int          g;
        logic [16:0] exp;
        g        = ref_grant(v0, v1);
        exp      = (g == 0) ? ref_result(oc0, a0, b0) : ref_result(oc1, a1, b1);
        mdl_last = g;
        req0_valid = v0; req0_oc = oc0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_oc = oc1; req1_a = a1; req1_b = b1;
        rsp_ready  = 1'b1;
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("grant_req0_ready", 32'(req0_ready), 32'(g == 0));
        check("grant_req1_ready", 32'(req1_ready), 32'(g == 1));
        @(negedge clk);
        // Scramble operands after acceptance; the in-flight result must not change.
        req0_oc = 4'($urandom); req0_a = 16'($urandom); req0_b = 16'($urandom);
        req1_oc = 4'($urandom); req1_a = 16'($urandom); req1_b = 16'($urandom);
        #1;
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_ready", 32'(req0_ready | req1_ready), 32'd0);
        @(negedge clk);
        check("resp_valid", 32'(rsp_valid), 32'd1);
        check("resp_id", 32'(rsp_id), 32'(g));
        check("resp_f", 32'(rsp_f), 32'(exp[15:0]));
        check("resp_err", 32'(rsp_err), 32'(exp[16]));
        check("resp_ready_low", 32'(req0_ready | req1_ready), 32'd0);
        @(negedge clk);
        check("back_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [16:0] exp;
        logic [3:0]  o0, o1;
        logic [15:0] x0, y0, x1, y1;
        int          v;

        // Reset with both requesters asserting valid.
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_oc = 4'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b1; req1_oc = 4'd0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;
        mdl_last = 1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_f", 32'(rsp_f), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // ADD 3+4 from requester 0.
        transact(1'b1, 4'd0, 16'd3, 16'd4, 1'b0, 4'd0, 16'd0, 16'd0);

        // Fresh reset, then both requesters contend: grants 0,1,0,1.
        rst_n = 1'b0; mdl_last = 1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            transact(1'b1, 4'd1, 16'd5, 16'd7, 1'b1, 4'd2, 16'h0100, 16'h0100);

        // Divide, illegal opcode and NOT corner cases.
        transact(1'b1, 4'd3, 16'd10, 16'd0, 1'b0, 4'd0, 16'd0, 16'd0);
        transact(1'b1, 4'd3, 16'd10, 16'd3, 1'b0, 4'd0, 16'd0, 16'd0);
        transact(1'b0, 4'd0, 16'd0, 16'd0, 1'b1, 4'b1000, 16'h1234, 16'h5678);
        transact(1'b1, 4'd4, 16'h00FF, 16'd0, 1'b0, 4'd0, 16'd0, 16'd0);

        // Stall in RESP for 5 cycles with requester 1 waiting.
        exp = ref_result(4'd5, 16'h1234, 16'h0F0F);
        mdl_last = ref_grant(1'b1, 1'b0);
        req0_valid = 1'b1; req0_oc = 4'd5; req0_a = 16'h1234; req0_b = 16'h0F0F;
        req1_valid = 1'b0; rsp_ready = 1'b1;
        #1 check("stall_accept", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b1; req1_oc = 4'd6; req1_a = 16'h00F0; req1_b = 16'h0F00;
        rsp_ready = 1'b0;
        #1 check("stall_exec_req1_ready", 32'(req1_ready), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_f", 32'(rsp_f), 32'(exp[15:0]));
            check("stall_rsp_id", 32'(rsp_id), 32'd0);
            check("stall_rsp_err", 32'(rsp_err), 32'(exp[16]));
            check("stall_req1_ready", 32'(req1_ready), 32'd0);
            @(negedge clk);
        end
        check("stall_still_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        #1 check("release_req1_ready", 32'(req1_ready), 32'd0);
        @(negedge clk);
        check("release_idle", 32'(rsp_valid), 32'd0);
        transact(1'b0, 4'd0, 16'd0, 16'd0, 1'b1, 4'd6, 16'h00F0, 16'h0F00);

        // Reset pulse during EXEC discards the operation.
        req0_valid = 1'b1; req0_oc = 4'd0; req0_a = 16'd1; req0_b = 16'd1; req1_valid = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst_n = 1'b0; mdl_last = 1;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rsp_f", 32'(rsp_f), 32'd0);
        check("midrst_rsp_id", 32'(rsp_id), 32'd0);
        check("midrst_rsp_err", 32'(rsp_err), 32'd0);
        check("midrst_ready", 32'(req0_ready | req1_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("postrst_no_rsp", 32'(rsp_valid), 32'd0);
            check("postrst_idle", 32'(busy), 32'd0);
        end
        transact(1'b1, 4'd7, 16'hF0F0, 16'h3C3C, 1'b1, 4'd6, 16'h0001, 16'h0002);

        // Randomized traffic with occasional idle cycles.
        for (int i = 0; i < 60; i++) begin
            v  = int'($urandom_range(1, 3));
            o0 = ($urandom_range(0, 7) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
            o1 = ($urandom_range(0, 7) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
            x0 = 16'($urandom);
            x1 = 16'($urandom);
            y0 = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            y1 = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            transact(v[0], o0, x0, y0, v[1], o1, x1, y1);
            if ($urandom_range(0, 3) == 0) begin
                req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'($urandom);
                @(negedge clk);
                check("rand_idle_busy", 32'(busy), 32'd0);
                check("rand_idle_rsp_valid", 32'(rsp_valid), 32'd0);
                check("rand_idle_ready", 32'(req0_ready | req1_ready), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
